// File: rtl/vram_port_arbiter.sv
// rtl/vram_port_arbiter.sv - VRAM port A arbiter: round-robin core/ICE plus idle-slot screen clear
// Clear engine is built only when VRAM_CLR_FILL_EN is defined.
module vram_port_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 3,
  parameter int RD_LAT = 2
) (
  input  logic              CLK96,
  input  logic              I_RESET,
  input  logic              I_CORE_REQ,
  input  logic              I_CORE_WE,
  input  logic [ADDR_W-1:0] I_CORE_ADDR,
  input  logic [DATA_W-1:0] I_CORE_WDATA,
  output logic              O_CORE_ACK,
  output logic [DATA_W-1:0] O_CORE_RDATA,
  input  logic              I_ICE_REQ,
  input  logic              I_ICE_WE,
  input  logic [ADDR_W-1:0] I_ICE_ADDR,
  input  logic [DATA_W-1:0] I_ICE_WDATA,
  output logic              O_ICE_ACK,
  output logic [DATA_W-1:0] O_ICE_RDATA,
  input  logic              I_CLR_START,
  input  logic [DATA_W-1:0] I_CLR_COLOR,
  output logic              O_CLR_BUSY,
  output logic              O_CLR_DONE,
  output logic [ADDR_W-1:0] O_VRAM_ADDR,
  output logic              O_VRAM_WE,
  output logic [DATA_W-1:0] O_VRAM_DIN,
  input  logic [DATA_W-1:0] I_VRAM_DOUT
);

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RDWAIT, ST_DONE} state_t;
  typedef enum logic [1:0] {OWN_CORE, OWN_ICE, OWN_CLR} owner_t;

  localparam logic [2:0] RD_LAST = 3'(RD_LAT - 1);

  state_t     state;
  owner_t     owner;
  logic       rr_last;  // 1 = ICE won the last tie, so core wins the next one
  logic [2:0] rd_cnt;
  logic       clr_busy;
  logic       clr_done;
  logic       grant_core;
  logic       grant_ice;

  always_comb begin
    grant_core = I_CORE_REQ && (!I_ICE_REQ || rr_last);
    grant_ice  = I_ICE_REQ && !grant_core;
  end

`ifdef VRAM_CLR_FILL_EN
  logic [ADDR_W-1:0] clr_cnt;
  logic [DATA_W-1:0] clr_color;

  always_ff @(posedge CLK96) begin
    if (I_RESET) begin
      clr_busy  <= 1'b0;
      clr_done  <= 1'b0;
      clr_cnt   <= '0;
      clr_color <= '0;
    end else begin
      clr_done <= 1'b0;
      if (!clr_busy && I_CLR_START) begin
        clr_busy  <= 1'b1;
        clr_color <= I_CLR_COLOR;
        clr_cnt   <= '0;
      end else if (state == ST_ACCESS && owner == OWN_CLR) begin
        clr_cnt <= clr_cnt + 1'b1;
        if (&clr_cnt) begin
          clr_busy <= 1'b0;
          clr_done <= 1'b1;
        end
      end
    end
  end
`else
  logic unused_clr;
  assign unused_clr = ^{I_CLR_START, I_CLR_COLOR};
  assign clr_busy   = 1'b0;
  assign clr_done   = 1'b0;
`endif

  assign O_CLR_BUSY = clr_busy;
  assign O_CLR_DONE = clr_done;

  always_ff @(posedge CLK96) begin
    if (I_RESET) begin
      state        <= ST_IDLE;
      owner        <= OWN_CORE;
      rr_last      <= 1'b1;
      rd_cnt       <= '0;
      O_CORE_ACK   <= 1'b0;
      O_ICE_ACK    <= 1'b0;
      O_CORE_RDATA <= '0;
      O_ICE_RDATA  <= '0;
      O_VRAM_ADDR  <= '0;
      O_VRAM_WE    <= 1'b0;
      O_VRAM_DIN   <= '0;
    end else begin
      O_CORE_ACK <= 1'b0;
      O_ICE_ACK  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_core || grant_ice) begin
            if (I_CORE_REQ && I_ICE_REQ) rr_last <= grant_ice;
            owner       <= grant_core ? OWN_CORE : OWN_ICE;
            O_VRAM_WE   <= grant_core ? I_CORE_WE : I_ICE_WE;
            O_VRAM_ADDR <= grant_core ? I_CORE_ADDR : I_ICE_ADDR;
            O_VRAM_DIN  <= grant_core ? I_CORE_WDATA : I_ICE_WDATA;
            state       <= ST_ACCESS;
          end
`ifdef VRAM_CLR_FILL_EN
          else if (clr_busy) begin
            owner       <= OWN_CLR;
            O_VRAM_WE   <= 1'b1;
            O_VRAM_ADDR <= clr_cnt;
            O_VRAM_DIN  <= clr_color;
            state       <= ST_ACCESS;
          end
`endif
        end
        ST_ACCESS: begin
          O_VRAM_WE <= 1'b0;
          rd_cnt    <= '0;
          if (owner == OWN_CLR) begin
            state <= ST_IDLE;
          end else if (O_VRAM_WE) begin
            O_CORE_ACK <= (owner == OWN_CORE);
            O_ICE_ACK  <= (owner == OWN_ICE);
            state      <= ST_DONE;
          end else begin
            state <= ST_RDWAIT;
          end
        end
        ST_RDWAIT: begin
          if (rd_cnt == RD_LAST) begin
            if (owner == OWN_CORE) O_CORE_RDATA <= I_VRAM_DOUT;
            else                   O_ICE_RDATA  <= I_VRAM_DOUT;
            O_CORE_ACK <= (owner == OWN_CORE);
            O_ICE_ACK  <= (owner == OWN_ICE);
            state      <= ST_DONE;
          end else begin
            rd_cnt <= rd_cnt + 3'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/vram_port_arbiter.md
Name: vram_port_arbiter

Overview:
- Owns VRAM port A (CLK96 domain) and shares it between three sources: CPU core draw/read requests, ICE debug accesses, and a built-in full-screen clear engine.
- One access is outstanding at a time.
- Core and ICE are arbitrated round-robin. The clear engine uses only the idle slots.
- Sits between core/ICE bus logic and the vram block's port A. All requesters are synchronous to CLK96; clock-domain crossing is out of scope.

Parameters:
ADDR_W, 16, VRAM word address width (256x256 pixels)
DATA_W, 3, pixel width
RD_LAT, 2, VRAM port A read latency in cycles (address edge to valid douta); legal range 1..4

Ports:
CLK96  in  1  clock
I_RESET  in  1  reset; synchronous, active-high, clock CLK96
I_CORE_REQ  in  1  core request; held until O_CORE_ACK
I_CORE_WE  in  1  1 = write, 0 = read
I_CORE_ADDR  in  ADDR_W  core address
I_CORE_WDATA  in  DATA_W  core write data
O_CORE_ACK  out  1  one-cycle completion pulse
O_CORE_RDATA  out  DATA_W  read data; valid while O_CORE_ACK=1, held until the next core read ack
I_ICE_REQ / I_ICE_WE / I_ICE_ADDR / I_ICE_WDATA  in  1/1/ADDR_W/DATA_W  ICE request, same rules as core
O_ICE_ACK  out  1  one-cycle completion pulse
O_ICE_RDATA  out  DATA_W  same rules as O_CORE_RDATA
I_CLR_START  in  1  one-cycle pulse; starts a clear
I_CLR_COLOR  in  DATA_W  fill colour; sampled on the start pulse
O_CLR_BUSY  out  1  clear in progress
O_CLR_DONE  out  1  one-cycle pulse when the clear completes
O_VRAM_ADDR  out  ADDR_W  VRAM port A address
O_VRAM_WE  out  1  VRAM port A write enable
O_VRAM_DIN  out  DATA_W  VRAM port A write data
I_VRAM_DOUT  in  DATA_W  VRAM port A read data

Behaviour:
- Reset: all outputs 0, FSM=IDLE, rr_last=ICE, clear counter 0. Any in-flight access or clear is abandoned with no ack and no done.
- Registered outputs only.
- States: IDLE, ACCESS, RDWAIT, DONE.
- IDLE, each cycle:
  - If both core and ICE request, grant the one not equal to rr_last, so core wins the first tie after reset. Set rr_last to the winner.
  - If only one of them requests, grant it.
  - On a grant, latch owner/we/addr/wdata and go to ACCESS.
  - Else, if O_CLR_BUSY=1, latch a clear write and go to ACCESS.
  - Else stay in IDLE.
- ACCESS (exactly 1 cycle): drive O_VRAM_ADDR, O_VRAM_DIN, O_VRAM_WE=latched we.
  - Clear write: return to IDLE, no ack.
  - Core/ICE write: go to DONE.
  - Read: go to RDWAIT.
- RDWAIT: O_VRAM_WE=0, address held. Count RD_LAT-1 cycles (zero cycles when RD_LAT=1), then sample I_VRAM_DOUT into the owner's RDATA register and go to DONE.
- DONE: owner's ACK=1 for one cycle, then IDLE.
- Latency, request high in cycle 0:
  - Write: WE=1 in cycle 1, ACK in cycle 2.
  - Read: ACK in cycle 2+RD_LAT.
- Requester rules:
  - Drop REQ, or present a new request, in the cycle after ACK. The arbiter does not sample REQ in DONE.
  - Changes to addr/data after the grant are ignored.
- O_VRAM_WE is high only in ACCESS for a write. Address and data hold their last value otherwise.
- Clear engine:
  - I_CLR_START while idle sets BUSY=1, latches the colour, and sets counter=0.
  - Each clear write uses addr=counter, then increments the counter.
  - After the write at 2^ADDR_W-1 (counter wrap), BUSY=0 and DONE=1 in the same cycle, i.e. the cycle after the last ACCESS.
  - I_CLR_START while BUSY is ignored and does not restart the clear.
  - Uncontended clear takes 2 cycles/pixel: 131072 cycles for 65536 pixels.
  - Clear never preempts a granted access. Core/ICE traffic stalls the clear but never corrupts the sequence.
  - Start and reset in the same cycle: reset wins.
- Simultaneous core REQ and clear pending in IDLE: core wins.

Optional Feature:
VRAM_CLR_FILL_EN:
- Defined: clear engine present as specified.
- Undefined: no clear counter or logic. I_CLR_START and I_CLR_COLOR are ignored, O_CLR_BUSY=0 and O_CLR_DONE=0 permanently. Core/ICE arbitration is unchanged.

Test Plan:
- Core write addr 0x1234 data 5 -> O_VRAM_WE=1 with O_VRAM_ADDR=0x1234, O_VRAM_DIN=5 in cycle 1; O_CORE_ACK in cycle 2; no ICE ack.
- ICE read of addr 0x00FF after pixel=3 is written there, RD_LAT=2 -> O_ICE_ACK in cycle 4 with O_ICE_RDATA=3; O_VRAM_WE stays 0.
- Core and ICE both hold REQ continuously after reset -> grants alternate core, ICE, core, ICE; each ack'd once per grant; no starvation.
- I_CLR_START with colour 6, no other traffic -> 65536 writes at addresses 0..0xFFFF with data 6; O_CLR_DONE exactly 131072 cycles after start; a second start mid-clear is ignored.
- Clear running, core write to 0x0010 injected -> core ack in ≤3 cycles; clear resumes at the next counter value; final memory is all 6 except 0x0010 if it was written after the clear passed it.
- Assert I_RESET during a read in RDWAIT and during a clear -> no ack, BUSY=0, DONE=0, all outputs 0 the following cycle; the next core write completes normally.
